// File: rtl/aud_sample_tx_if.sv
// Sample handshake bundle between the capture front-end/filter side and aud_sample_tx.
// master drives strobes, enable and rtr; slave returns rts, the presented sample and FIFO status.
interface aud_sample_tx_if #(
  parameter int WIDTH = 16,
  parameter int PTR   = 3
);
  logic             enable;
  logic             smp_valid;
  logic [WIDTH-1:0] smp_data;
  logic             rtr;
  logic             ovf_clr;
  logic             rts;
  logic [WIDTH-1:0] aud_out;
  logic [PTR:0]     fifo_level;
  logic             overflow;

  modport master (
    output enable, smp_valid, smp_data, rtr, ovf_clr,
    input  rts, aud_out, fifo_level, overflow
  );

  modport slave (
    input  enable, smp_valid, smp_data, rtr, ovf_clr,
    output rts, aud_out, fifo_level, overflow
  );
endinterface

// File: rtl/aud_sample_tx.sv
// Buffers strobed audio samples in a 2**PTR FIFO and presents them one at a time on rts/rtr.
// First sample is presented one edge after capture; rtr low holds aud_out/rts, samples queue, full drops set overflow.
module aud_sample_tx #(
  parameter int WIDTH = 16,
  parameter int PTR   = 3
) (
  input logic            clk,
  input logic            rst,
  aud_sample_tx_if.slave bus
);
  localparam int DEPTH = 1 << PTR;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic             rts_q, rts_d;
  logic [WIDTH-1:0] aud_q, aud_d;
  logic [PTR:0]     wr_q, wr_d;
  logic [PTR:0]     rd_q, rd_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR:0] level;
  logic         full;
  logic         empty;
  logic         pop;
  logic         push;

  // Counters carry one extra bit so full and empty are distinguishable.
  assign level = wr_q - rd_q;
  assign full  = (level == (PTR+1)'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    state_d = state_q;
    rts_d   = rts_q;
    aud_d   = aud_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable && !empty) begin
          pop     = 1'b1;
          rts_d   = 1'b1;
          state_d = SEND;
        end
      end
      default: begin
        if (bus.rtr) begin
          if (bus.enable && !empty) begin
            pop = 1'b1;
          end else begin
            rts_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
    endcase

    if (pop) begin
      aud_d = mem_q[rd_q[PTR-1:0]];
      rd_d  = rd_q + 1'b1;
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push = bus.smp_valid && (!full || pop);
    if (push) begin
      wr_d = wr_q + 1'b1;
    end

    if (bus.smp_valid && full && !pop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rts_q   <= 1'b0;
      aud_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rts_q   <= rts_d;
      aud_q   <= aud_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[PTR-1:0]] <= bus.smp_data;
    end
  end

  assign bus.rts        = rts_q;
  assign bus.aud_out    = aud_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf_q;
endmodule
